// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, HD44780 command bytes, default timing constants and
// small helpers for the character-LCD bus scheduler.
//   - lcd_state_e      : scheduler FSM states
//   - LCD_* constants  : HD44780 command bytes used by init and requesters
//   - DEF_* constants  : default timing (clock counts at 50 MHz)
//   - init_rom()       : power-up init command sequence
//   - needs_long_gap() : true for commands that need the extended settle time
//   - max4()           : width helper for the shared timing counter
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_IDLE  = 3'd4
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0E;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_HOME     = 8'h02;
    localparam logic [7:0] LCD_HOME_ALT = 8'h03;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam int unsigned DEF_EN_CYCLES       = 32'd50_000;
    localparam int unsigned DEF_GAP_CYCLES      = 32'd50_000;
    localparam int unsigned DEF_LONG_GAP_CYCLES = 32'd100_000;
    localparam int unsigned DEF_POWERUP_CYCLES  = 32'd750_000;

    // Init ROM: function set, display on, clear, entry mode.
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] byte_v;
        case (idx)
            2'd0:    byte_v = LCD_FUNC_SET;
            2'd1:    byte_v = LCD_DISP_ON;
            2'd2:    byte_v = LCD_CLEAR;
            2'd3:    byte_v = LCD_ENTRY;
            default: byte_v = LCD_FUNC_SET;
        endcase
        return byte_v;
    endfunction

    // Clear and the two return-home encodings take far longer inside the
    // controller, so they get the long settle window.
    function automatic logic needs_long_gap(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) &&
               ((data == LCD_CLEAR) || (data == LCD_HOME) || (data == LCD_HOME_ALT));
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// lcd_rr_arbiter: 2-way round-robin grant selection.
//   clk, rst   : clock, asynchronous active-high reset
//   valid_i    : [0] requester 0 valid, [1] requester 1 valid
//   accept_i   : a grant was consumed this cycle; update last-served pointer
//   grant_o    : index of the requester currently granted (combinational)
// Last-served resets to 1 so requester 0 wins the first tie.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic       grant_o
);

    logic last_q;
    logic last_d;
    logic grant_s;

    // Grant: a lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        grant_s = ~last_q;
        case (valid_i)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_q;
            default: grant_s = ~last_q;
        endcase
    end

    // Pointer next-state: remember whoever was just accepted.
    always_comb begin
        if (accept_i) begin
            last_d = grant_s;
        end else begin
            last_d = last_q;
        end
    end

    // Last-served pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign grant_o = grant_s;

endmodule

// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: owns the HD44780 bus. Runs power-up wait and the init
// sequence, then serves two requesters round-robin, emitting each byte as
// SETUP (RS/data valid, EN low) -> PULSE (EN high) -> GAP (EN low settle).
//   clk, rst                    : clock, asynchronous active-high reset
//   reqN_valid/rs/data (N=0,1)  : held stable by requester until reqN_ready
//   reqN_ready                  : combinational accept strobe
//   lcd_data, lcd_en, lcd_rs    : registered LCD pins; lcd_rw tied to 0
//   init_done                   : init sequence finished (sticky until reset)
//   busy                        : high in every state except IDLE
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYCLES       = DEF_EN_CYCLES,
    parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int unsigned LONG_GAP_CYCLES = DEF_LONG_GAP_CYCLES,
    parameter int unsigned POWERUP_CYCLES  = DEF_POWERUP_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       init_done,
    output logic       busy
);

    localparam int unsigned MAX_CYC = max4(EN_CYCLES, GAP_CYCLES, LONG_GAP_CYCLES, POWERUP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t PWR_LAST  = cnt_t'(POWERUP_CYCLES - 1);
    localparam cnt_t EN_LAST   = cnt_t'(EN_CYCLES - 1);
    localparam cnt_t GAP_LAST  = cnt_t'(GAP_CYCLES - 1);
    localparam cnt_t LGAP_LAST = cnt_t'(LONG_GAP_CYCLES - 1);

    lcd_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic       init_done_q, init_done_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       en_q;
    logic       busy_q;

    logic       grant_s;
    logic       can_accept_s;
    logic       ready0_s;
    logic       ready1_s;
    logic       accept_s;
    cnt_t       gap_last_s;

    lcd_rr_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  ({req1_valid, req0_valid}),
        .accept_i (accept_s),
        .grant_o  (grant_s)
    );

    // Ready is derived from registered state/pointer plus the live valid.
    always_comb begin
        can_accept_s = (state_q == ST_IDLE) && init_done_q;
        ready0_s     = can_accept_s && (grant_s == 1'b0) && req0_valid;
        ready1_s     = can_accept_s && (grant_s == 1'b1) && req1_valid;
        accept_s     = ready0_s || ready1_s;
    end

    // Settle length depends on the byte currently held on the bus.
    always_comb begin
        if (needs_long_gap(rs_q, data_q)) begin
            gap_last_s = LGAP_LAST;
        end else begin
            gap_last_s = GAP_LAST;
        end
    end

    // Main sequencer next-state; the counter restarts at 0 on each state entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        data_d      = data_q;
        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_rom(2'd0);
                end else begin
                    state_d = ST_PWRUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = '0;
            end
            ST_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_GAP: begin
                if (cnt_q == gap_last_s) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 2'd3) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        data_d  = init_rom(idx_q + 2'd1);
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (accept_s) begin
                    state_d = ST_SETUP;
                    if (grant_s) begin
                        rs_d   = req1_rs;
                        data_d = req1_data;
                    end else begin
                        rs_d   = req0_rs;
                        data_d = req0_data;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, latched byte and registered pin/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            en_q        <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            en_q        <= (state_d == ST_PULSE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_en     = en_q;
    assign lcd_rw     = 1'b0;
    assign init_done  = init_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
module tb_lcd_bus_scheduler;

    localparam int EN   = 4;
    localparam int GAP  = 3;
    localparam int LGAP = 8;
    localparam int PWR  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_rs, req1_valid, req1_rs;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic [7:0] lcd_data;
    logic       lcd_en, lcd_rw, lcd_rs, init_done, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    lcd_bus_scheduler #(
        .EN_CYCLES       (EN),
        .GAP_CYCLES      (GAP),
        .LONG_GAP_CYCLES (LGAP),
        .POWERUP_CYCLES  (PWR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lcd_data   (lcd_data),
        .lcd_en     (lcd_en),
        .lcd_rw     (lcd_rw),
        .lcd_rs     (lcd_rs),
        .init_done  (init_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       v0;
        logic       rs0;
        logic [7:0] d0;
        logic       v1;
        logic       rs1;
        logic [7:0] d1;
        int         gnt;
        logic       ers;
        logic [7:0] edat;
        int         gap;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Checks SETUP, EN pulse and settle window of one write; starts one cycle
    // before SETUP and ends on the last settle cycle.
    task automatic expect_write(input logic rs, input logic [7:0] data, input int gap,
                                input int drop, input logic idone);
        int   total;
        logic en_exp;
        total = 1 + EN + gap;
        for (int c = 0; c < total; c++) begin
            tick;
            if (c == 0) begin
                if (drop == 0) req0_valid = 1'b0;
                else if (drop == 1) req1_valid = 1'b0;
            end
            #1;
            en_exp = (c >= 1) && (c <= EN);
            chk($sformatf("bus_%02h_c%0d", data, c),
                {17'd0, lcd_rw, busy, lcd_en, lcd_rs, lcd_data, req1_ready, req0_ready, init_done},
                {17'd0, 1'b0, 1'b1, en_exp, rs, data, 1'b0, 1'b0, idone});
        end
    endtask

    task automatic init_sequence;
        for (int c = 0; c < PWR - 1; c++) begin
            tick;
            #1;
            chk("pwrup", {26'd0, lcd_en, init_done, req1_ready, req0_ready, busy, lcd_rw},
                {26'd0, 6'b000010});
        end
        expect_write(1'b0, 8'h38, GAP,  -1, 1'b0);
        expect_write(1'b0, 8'h0E, GAP,  -1, 1'b0);
        expect_write(1'b0, 8'h01, LGAP, -1, 1'b0);
        expect_write(1'b0, 8'h06, GAP,  -1, 1'b0);
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        while (!(req0_ready || req1_ready) && waited < 60) begin
            tick;
            #1;
            waited++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int acc_cyc;
        int prev_acc;
        int prev_gap;
        int en_seen;

        vecs[0]  = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h41, GAP};
        vecs[1]  = '{1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 8'h61, 1, 1'b1, 8'h61, GAP};
        vecs[2]  = '{1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 8'h62, 0, 1'b1, 8'h42, GAP};
        vecs[3]  = '{1'b1, 1'b1, 8'h43, 1'b1, 1'b1, 8'h62, 1, 1'b1, 8'h62, GAP};
        vecs[4]  = '{1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h43, GAP};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1, 1'b0, 8'h01, LGAP};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC0, 1, 1'b0, 8'hC0, GAP};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1, 1'b0, 8'h02, LGAP};
        vecs[8]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h03, LGAP};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1, 1'b1, 8'h01, GAP};
        vecs[10] = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h04, GAP};
        vecs[11] = '{1'b1, 1'b1, 8'h31, 1'b1, 1'b1, 8'h30, 1, 1'b1, 8'h30, GAP};
        vecs[12] = '{1'b1, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h31, GAP};

        rst        = 1'b1;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
        tick; tick; tick;
        #1;
        chk("reset_vals",
            {16'd0, lcd_data, lcd_en, lcd_rw, lcd_rs, init_done, busy, req0_ready, req1_ready, 1'b0},
            {16'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tick;
        rst = 1'b0;
        init_sequence;

        // Table-driven requests; each accept must land the cycle the bus frees.
        prev_acc = 0;
        prev_gap = 0;
        for (int i = 0; i < 13; i++) begin
            tick;
            req0_valid = vecs[i].v0; req0_rs = vecs[i].rs0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_rs = vecs[i].rs1; req1_data = vecs[i].d1;
            #1;
            chk($sformatf("idle_status_%0d", i), {30'd0, init_done, busy}, {30'd0, 1'b1, 1'b0});
            wait_ready(w);
            chk($sformatf("latency_%0d", i), w, 0);
            acc_cyc = cyc;
            chk($sformatf("grant_%0d", i), {30'd0, req1_ready, req0_ready},
                (vecs[i].gnt == 1) ? 32'd2 : 32'd1);
            if (i > 0) begin
                chk($sformatf("spacing_%0d", i), acc_cyc - prev_acc, 2 + EN + prev_gap);
            end
            prev_acc = acc_cyc;
            prev_gap = vecs[i].gap;
            expect_write(vecs[i].ers, vecs[i].edat, vecs[i].gap, vecs[i].gnt, 1'b1);
        end

        // Reset while EN is high during init, with both requesters pending.
        tick;
        rst = 1'b1;
        tick;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h5A;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h7B;
        tick;
        rst = 1'b0;
        for (int c = 0; c < PWR - 1; c++) begin
            tick;
        end
        expect_write(1'b0, 8'h38, GAP, -1, 1'b0);
        tick; tick; tick;
        #1;
        chk("pre_rst_en", {31'd0, lcd_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vals",
            {16'd0, lcd_data, lcd_en, lcd_rw, lcd_rs, init_done, busy, req0_ready, req1_ready, 1'b0},
            {16'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tick;
        rst = 1'b0;
        init_sequence;
        tick;
        #1;
        chk("tie_after_rst", {29'd0, init_done, req1_ready, req0_ready}, {29'd0, 3'b101});
        expect_write(1'b1, 8'h5A, GAP, 0, 1'b1);
        tick;
        #1;
        chk("second_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        expect_write(1'b1, 8'h7B, GAP, 1, 1'b1);
        en_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            #1;
            if (lcd_en || req0_ready || req1_ready) en_seen++;
        end
        chk("no_repeat_write", en_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Shares the HD44780-style character LCD bus between two independent write requesters (e.g. status-line writer and value-line writer). It runs the power-up init sequence itself, then arbitrates round-robin between requesters and sequences each accepted byte onto the bus with correct RS setup, EN pulse width and post-write settle time. Sits between the display-formatting logic and the LCD pins.

## Interface
- EN_CYCLES, 50_000, clocks EN held high per write (1 ms at 50 MHz)
- GAP_CYCLES, 50_000, EN-low settle clocks after a normal write
- LONG_GAP_CYCLES, 100_000, settle clocks after clear/home commands
- POWERUP_CYCLES, 750_000, wait after reset before first init command
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a byte; must hold valid/rs/data stable until accepted
- req0_rs  in  1  0 = command, 1 = character
- req0_data  in  8  byte to write
- req0_ready  out  1  acceptance strobe for requester 0
- req1_valid, req1_rs, req1_data, req1_ready  same as requester 0
- lcd_data  out  8  LCD data bus
- lcd_en  out  1  LCD enable
- lcd_rw  out  1  LCD read/write, constant 0
- lcd_rs  out  1  LCD register select
- init_done  out  1  init sequence complete
- busy  out  1  high in every state except IDLE

## Operation
- States: PWRUP, SETUP, PULSE, GAP, IDLE. Reset state PWRUP.
- PWRUP: count POWERUP_CYCLES, then SETUP with init index 0.
- Init ROM (rs=0): 0x38, 0x0E, 0x01, 0x06. Each goes SETUP→PULSE→GAP; after index 3's GAP, init_done=1 and → IDLE. init_done stays 1 until reset.
- IDLE: ready_i = init_done && grant==i && req_i_valid (combinational from registered grant/state). On valid&&ready, latch {rs,data} → SETUP.
- Arbitration: round-robin; with both valid, grant goes to the requester not served last. After reset, last-served = 1, so req0 wins first tie. Single valid requester is granted regardless of pointer.
- SETUP (1 cycle): lcd_rs/lcd_data driven from latch, lcd_en=0.
- PULSE: lcd_en=1 for EN_CYCLES; lcd_data/lcd_rs held.
- GAP: lcd_en=0, lcd_data/lcd_rs held; length LONG_GAP_CYCLES if rs=0 and data ∈ {0x01,0x02,0x03}, else GAP_CYCLES; then → IDLE (or next init step).
- Requests arriving during init or any non-IDLE state wait; nothing is dropped or queued beyond the held valid.
- Reset mid-operation: all outputs go to reset values immediately, init_done=0, pending requester is not consumed; full power-up and init rerun.

## Timing
- All outputs except reqN_ready are registered.
- Reset values: lcd_data=0x00, lcd_en=0, lcd_rw=0, lcd_rs=0, init_done=0, busy=1, req0_ready=0, req1_ready=0.
- Accept at cycle T: SETUP at T+1, lcd_en high T+2..T+1+EN_CYCLES, GAP follows, IDLE at T+2+EN_CYCLES+gap; earliest next accept that cycle.
- Per-write bus occupancy: 2+EN_CYCLES+gap clocks.
- Counters sized for max parameter; counter resets to 0 on every state entry.

## Structure
- Package lcd_pkg: state enum; command constants LCD_FUNC_SET=0x38, LCD_DISP_ON=0x0E, LCD_CLEAR=0x01, LCD_HOME=0x02, LCD_ENTRY=0x06, LCD_LINE2=0xC0; default timing constants.
- One sub-module: lcd_rr_arbiter (2-way round-robin, last-served pointer updated on accept).

## Test plan
Bench params: EN_CYCLES=4, GAP_CYCLES=3, LONG_GAP_CYCLES=8, POWERUP_CYCLES=10.
- Reset release, no requests → after 10 cycles bus shows 0x38,0x0E,0x01,0x06, rs=0, EN high 4 cycles each, gap 8 after 0x01, 3 otherwise; init_done rises at end; no ready before.
- req0 rs=1 data=0x41 after init → ready one cycle, lcd_rs=1/data=0x41 one cycle before EN, EN high 4, next accept 9 cycles after first.
- req0 and req1 valid continuously → grants 0,1,0,1; data on bus alternates accordingly.
- req1 command 0x01 then 0xC0 → gap 8 after 0x01, gap 3 after 0xC0.
- rst pulsed during PULSE with req0 valid → lcd_en=0 immediately, init_done=0, init reruns, then req0's byte written once.
- Throughout all scenarios lcd_rw=0.
